// File: rtl/ddcb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : ddcb_pkg                                                        |
// | Purpose  : Shared types and step-to-select encoding for the delay-line     |
// |            calibration controller.                                         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package ddcb_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        APPLY  = 3'd1,
        SETTLE = 3'd2,
        SAMPLE = 3'd3,
        EVAL   = 3'd4,
        DONE   = 3'd5
    } cal_state_t;

    // Per-stage mux select codes; 2'b11 is never produced.
    localparam logic [1:0] c_sel_i0 = 2'b00;
    localparam logic [1:0] c_sel_i1 = 2'b01;
    localparam logic [1:0] c_sel_i2 = 2'b10;

    localparam int c_max_cascades = 16;
    localparam int c_max_sel_w    = 2 * c_max_cascades;

    // Buffers used by stage g for total step k; the last stage fills first.
    function automatic logic [1:0] stage_sel(input int step, input int g, input int n);
        int b;
        b = step - 2 * (n - 1 - g);
        if (b <= 0) begin
            return c_sel_i0;
        end else if (b == 1) begin
            return c_sel_i1;
        end
        return c_sel_i2;
    endfunction

    function automatic logic [c_max_sel_w-1:0] step_to_select(input int step, input int n);
        logic [c_max_sel_w-1:0] sel;
        sel = '0;
        for (int g = 0; g < n && g < c_max_cascades; g++) begin
            sel[2*g +: 2] = stage_sel(step, g, n);
        end
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/delay_step_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : delay_step_encoder                                              |
// | Purpose  : Combinational map from a buffer-count step to the delay line's  |
// |            select word.                                                    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module delay_step_encoder
    import ddcb_pkg::*;
#(
    parameter int NMBR_CASCADES = 4,
    parameter int CODE_W        = $clog2(2 * NMBR_CASCADES + 1)
) (
    input  logic [CODE_W-1:0]          i_step,
    output logic [2*NMBR_CASCADES-1:0] o_select
);

    for (genvar g = 0; g < NMBR_CASCADES; g++) begin : g_stage
        assign o_select[2*g +: 2] = stage_sel(int'(i_step), g, NMBR_CASCADES);
    end

endmodule
`default_nettype wire

// File: rtl/delay_cal_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : delay_cal_ctrl                                                  |
// | Purpose  : Sweeps the cascade_delays step, majority-votes the phase        |
// |            detector and locks the first flipping step; manual override.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module delay_cal_ctrl
    import ddcb_pkg::*;
#(
    parameter int NMBR_CASCADES = 4,
    parameter int SETTLE_CYC    = 8,
    parameter int SAMPLES       = 5,
    parameter int CODE_W        = $clog2(2 * NMBR_CASCADES + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       man_en,
    input  logic [CODE_W-1:0]          man_code,
    input  logic                       pd_in,
    output logic [2*NMBR_CASCADES-1:0] select,
    output logic                       busy,
    output logic                       done,
    output logic                       locked,
    output logic                       fail,
    output logic [CODE_W-1:0]          lock_code
);

    localparam int c_sel_w   = 2 * NMBR_CASCADES;
    localparam int c_cnt_max = (SETTLE_CYC > SAMPLES) ? SETTLE_CYC : SAMPLES;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
    localparam int c_ones_w  = $clog2(SAMPLES + 1);

    localparam logic [CODE_W-1:0]   c_last_step   = CODE_W'(2 * NMBR_CASCADES);
    localparam logic [c_cnt_w-1:0]  c_settle_last = c_cnt_w'(SETTLE_CYC - 1);
    localparam logic [c_cnt_w-1:0]  c_sample_last = c_cnt_w'(SAMPLES - 1);
    localparam logic [c_ones_w-1:0] c_half        = c_ones_w'(SAMPLES / 2);

    cal_state_t          r_state;
    logic [CODE_W-1:0]   r_step;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_ones_w-1:0] r_ones;
    logic                r_ref;

    logic [CODE_W-1:0]   w_man_step;
    logic [CODE_W-1:0]   w_enc_step;
    logic [c_sel_w-1:0]  w_enc_sel;
    logic                w_vote;

    assign w_man_step = (man_code > c_last_step) ? c_last_step : man_code;
    assign w_vote     = (r_ones > c_half);

    // The encoder only feeds select in IDLE (manual), APPLY and the EVAL fail path.
    always_comb begin
        w_enc_step = r_step;
        case (r_state)
            IDLE:    w_enc_step = w_man_step;
            EVAL:    w_enc_step = '0;
            default: w_enc_step = r_step;
        endcase
    end

    delay_step_encoder #(
        .NMBR_CASCADES (NMBR_CASCADES),
        .CODE_W        (CODE_W)
    ) u_enc (
        .i_step   (w_enc_step),
        .o_select (w_enc_sel)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_step    <= '0;
            r_cnt     <= '0;
            r_ones    <= '0;
            r_ref     <= 1'b0;
            select    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            locked    <= 1'b0;
            fail      <= 1'b0;
            lock_code <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (man_en) begin
                        select <= w_enc_sel;
                    end else if (start) begin
                        r_step  <= '0;
                        locked  <= 1'b0;
                        fail    <= 1'b0;
                        busy    <= 1'b1;
                        r_state <= APPLY;
                    end
                end
                APPLY: begin
                    select  <= w_enc_sel;
                    r_cnt   <= '0;
                    r_state <= SETTLE;
                end
                SETTLE: begin
                    if (r_cnt == c_settle_last) begin
                        r_cnt   <= '0;
                        r_ones  <= '0;
                        r_state <= SAMPLE;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                SAMPLE: begin
                    r_ones <= r_ones + c_ones_w'(pd_in);
                    if (r_cnt == c_sample_last) begin
                        r_state <= EVAL;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                EVAL: begin
                    if (r_step == '0) begin
                        r_ref   <= w_vote;
                        r_step  <= CODE_W'(1);
                        r_state <= APPLY;
                    end else if (w_vote != r_ref) begin
                        lock_code <= r_step;
                        locked    <= 1'b1;
                        done      <= 1'b1;
                        r_state   <= DONE;
                    end else if (r_step == c_last_step) begin
                        fail      <= 1'b1;
                        lock_code <= '0;
                        select    <= w_enc_sel;
                        done      <= 1'b1;
                        r_state   <= DONE;
                    end else begin
                        r_step  <= r_step + CODE_W'(1);
                        r_state <= APPLY;
                    end
                end
                DONE: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
